// File: rtl/mw_add_ctrl_if.sv
// Requester-side handshake and operand/result bundle for the wide add/sub sequencer.
interface mw_add_ctrl_if #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned WORDS = 4
) ();
  localparam int unsigned W = SIZE * WORDS;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         co;
  logic         ovf;

  modport master (
    output start, sub, a, b, ci,
    input  busy, done, sum, co, ovf
  );

  modport slave (
    input  start, sub, a, b, ci,
    output busy, done, sum, co, ovf
  );
endinterface

// File: rtl/mw_add_ctrl.sv
// Wide adder/subtractor that reuses one SIZE-bit ripple slice, one slice per cycle, LSB first.
// The slice also exposes its carry into the MSB so the sequencer can derive signed overflow.
module fa_multi_bit #(
  parameter int unsigned SIZE = 4
) (
  input  logic [SIZE-1:0] a_i,
  input  logic [SIZE-1:0] b_i,
  input  logic            ci_i,
  output logic [SIZE-1:0] s_o,
  output logic            co_o,
  output logic            c_msb_o
);
  logic [SIZE:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = ci_i;
    for (int i = 0; i < int'(SIZE); i++) begin
      s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]  = (a_i[i] & b_i[i]) | (a_i[i] & c[i]) | (b_i[i] & c[i]);
    end
    co_o    = c[SIZE];
    c_msb_o = c[SIZE-1];
  end
endmodule

module mw_add_ctrl #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned WORDS = 4
) (
  input  logic           clk,
  input  logic           rst,
  mw_add_ctrl_if.slave   bus
);
  localparam int unsigned W    = SIZE * WORDS;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      opa_q, opa_d;
  logic [W-1:0]      opb_q, opb_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              co_q, co_d;
  logic              ovf_q, ovf_d;

  logic [SIZE-1:0]   slice_a, slice_b, slice_s;
  logic              slice_co, slice_cmsb;

  assign slice_a = opa_q[idx_q*SIZE +: SIZE];
  assign slice_b = opb_q[idx_q*SIZE +: SIZE];

  fa_multi_bit #(
    .SIZE (SIZE)
  ) u_slice (
    .a_i     (slice_a),
    .b_i     (slice_b),
    .ci_i    (carry_q),
    .s_o     (slice_s),
    .co_o    (slice_co),
    .c_msb_o (slice_cmsb)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (idx_q == LastIdx) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          opa_d   = bus.a;
          // Subtract as a + ~b + 1; the add carry-in is ignored.
          opb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.ci;
          idx_d   = '0;
          sum_d   = '0;
          co_d    = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      StRun: begin
        sum_d[idx_q*SIZE +: SIZE] = slice_s;
        carry_d = slice_co;
        if (idx_q == LastIdx) begin
          co_d  = slice_co;
          ovf_d = slice_cmsb ^ slice_co;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs decode registered state only
  always_comb begin
    bus.busy = (state_q != StIdle);
    bus.done = (state_q == StDone);
    bus.sum  = sum_q;
    bus.co   = co_q;
    bus.ovf  = ovf_q;
  end
endmodule

// File: tb/tb_mw_add_ctrl.sv
// Directed bench for mw_add_ctrl: a 4x4-bit instance and a 1x8-bit instance sharing clk/rst.
module tb_mw_add_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mw_add_ctrl_if #(.SIZE(4), .WORDS(4)) bus0 ();
  mw_add_ctrl_if #(.SIZE(8), .WORDS(1)) bus1 ();

  mw_add_ctrl #(.SIZE(4), .WORDS(4)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mw_add_ctrl #(.SIZE(8), .WORDS(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation on the 16-bit instance and check latency, busy span and result.
  // With hold set, start stays high and the operands churn while the op is in flight.
  task automatic do_op(input string tag, input logic s, input logic [15:0] av,
                       input logic [15:0] bv, input logic c, input logic hold,
                       input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    int nbusy;
    lat   = 0;
    nbusy = 0;
    @(negedge clk);
    bus0.start = 1'b1;
    bus0.sub   = s;
    bus0.a     = av;
    bus0.b     = bv;
    bus0.ci    = c;
    @(posedge clk);
    @(negedge clk);
    bus0.start = hold;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (bus0.busy) nbusy++;
      if (bus0.done) begin
        lat = k;
        break;
      end
      if (hold) begin
        bus0.start = 1'b1;
        bus0.a     = 16'($urandom);
        bus0.b     = 16'($urandom);
        bus0.sub   = 1'($urandom);
        bus0.ci    = 1'($urandom);
      end
    end
    check({tag, "_lat"}, lat, 5);
    check({tag, "_busy"}, nbusy, 5);
    check({tag, "_sum"}, bus0.sum, es);
    check({tag, "_co"}, bus0.co, ec);
    check({tag, "_ovf"}, bus0.ovf, eo);
  endtask

  initial begin
    int lat;
    int seen;
    bus0.start = 1'b0; bus0.sub = 1'b0; bus0.a = '0; bus0.b = '0; bus0.ci = 1'b0;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0; bus1.ci = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus0.busy, 0);
    check("rst_done", bus0.done, 0);
    check("rst_sum",  bus0.sum, 0);
    check("rst_co",   bus0.co, 0);
    check("rst_ovf",  bus0.ovf, 0);
    rst = 1'b0;

    do_op("add_basic", 1'b0, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    do_op("ripple",    1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("cin",       1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
    do_op("ovf_pos",   1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("ovf_neg",   1'b0, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    do_op("sub_neg",   1'b1, 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_pos",   1'b1, 16'h0007, 16'h0005, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0);
    // Held start with churning operands, then an immediate back-to-back op.
    do_op("hold",      1'b0, 16'h0F0F, 16'h0101, 1'b0, 1'b1, 16'h1010, 1'b0, 1'b0);
    do_op("b2b",       1'b0, 16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    bus0.start = 1'b0;
    @(negedge clk);
    check("post_done", bus0.done, 0);
    check("post_busy", bus0.busy, 0);
    check("post_hold", bus0.sum, 16'h8000);

    // Reset in the second RUN cycle.
    bus0.start = 1'b1; bus0.sub = 1'b0; bus0.a = 16'hFFFF; bus0.b = 16'h1111; bus0.ci = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus0.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", bus0.busy, 0);
    check("mid_rst_done", bus0.done, 0);
    check("mid_rst_sum",  bus0.sum, 0);
    check("mid_rst_co",   bus0.co, 0);
    check("mid_rst_ovf",  bus0.ovf, 0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus0.done || bus0.busy) seen++;
    end
    check("mid_rst_quiet", seen, 0);
    do_op("after_rst", 1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Single-slice instance.
    @(negedge clk);
    bus1.start = 1'b1; bus1.sub = 1'b0; bus1.a = 8'hFF; bus1.b = 8'h01; bus1.ci = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus1.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      if (bus1.done) begin
        lat = k;
        break;
      end
    end
    check("w1_lat", lat, 2);
    check("w1_sum", bus1.sum, 8'h00);
    check("w1_co",  bus1.co, 1);
    check("w1_ovf", bus1.ovf, 0);

    @(negedge clk);
    bus1.start = 1'b1; bus1.sub = 1'b1; bus1.a = 8'h80; bus1.b = 8'h01; bus1.ci = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus1.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      if (bus1.done) begin
        lat = k;
        break;
      end
    end
    check("w1s_lat", lat, 2);
    check("w1s_sum", bus1.sum, 8'h7F);
    check("w1s_co",  bus1.co, 1);
    check("w1s_ovf", bus1.ovf, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mw_add_ctrl.md
Name: mw_add_ctrl

Overview:
Multi-cycle sequencer for wide additions and subtractions. It reuses one SIZE-bit ripple adder slice, an fa_multi_bit instance with SIZE passed through, to add or subtract WORDS*SIZE-bit operands. Each cycle it processes one slice, LSB slice first, and carries between slices through a register. It sits between a requester (start/done handshake) and the shared narrow adder, trading latency for area.

Parameters:
SIZE, 4, width of the adder slice in bits (>=1)
WORDS, 4, number of slices per operand (>=1); W = SIZE*WORDS is the full operand width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
sub  input  1  0 = a+b+ci, 1 = a-b (two's complement; ci ignored); sampled with start
a  input  W  operand A; sampled with start
b  input  W  operand B; sampled with start
ci  input  1  carry-in for add; sampled with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result valid
sum  output  W  result register
co  output  1  carry out of the MSB slice (sub: 1 = no borrow)
ovf  output  1  signed overflow: carry into the final MSB XOR carry out of it

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; busy=0, done=0, sum=0, co=0, ovf=0; internal idx, carry and operand registers cleared. Reset overrides all other activity, including mid-RUN; no partial result is retained.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch a into opa.
  - Latch opb = sub ? ~b : b.
  - Set carry = sub ? 1 : ci, idx=0.
  - Clear sum, co and ovf; go to RUN. Otherwise stay.
- RUN, each cycle:
  - The adder slice sees opa[idx*SIZE +: SIZE], opb[idx*SIZE +: SIZE] and carry.
  - The slice sum is written to sum[idx*SIZE +: SIZE]; carry <= slice carry-out.
  - When idx == WORDS-1: co <= slice carry-out; ovf <= slice internal carry into bit SIZE-1 XOR slice carry-out; go to DONE. Otherwise idx <= idx+1.
- DONE: done=1 for exactly this cycle; go to IDLE. start is ignored in DONE.
- Latency: start accepted at edge T; done is high during cycle T+WORDS+1. The next start can be accepted in the cycle after done.
- start, a, b, ci and sub are ignored while busy=1; the latched operands are used throughout.
- sum, co and ovf hold their final values after done until the next accepted start or reset. sum is not valid while busy.
- WORDS=1: RUN lasts one cycle; done is high 2 cycles after start.
- idx width is clog2(WORDS), minimum 1 bit. No wrap beyond WORDS-1.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. SIZE=4, WORDS=4: a=16'h1234, b=16'h1111, ci=0, sub=0 -> sum=16'h2345, co=0, ovf=0; done exactly 5 cycles after the start edge; busy high for 5 cycles.
2. a=16'hFFFF, b=16'h0001, ci=0 -> sum=16'h0000, co=1, ovf=0; the carry ripples through all 4 slice registers. Also a=16'h0000, b=16'h0000, ci=1 -> sum=16'h0001.
3. Signed overflow: a=16'h7FFF, b=16'h0001, add -> sum=16'h8000, co=0, ovf=1. a=16'h8000, b=16'h8000 -> sum=16'h0000, co=1, ovf=1.
4. Subtract: sub=1, a=16'h0005, b=16'h0007, ci=1 (ignored) -> sum=16'hFFFE, co=0, ovf=0. sub=1, a=16'h0007, b=16'h0005 -> sum=16'h0002, co=1.
5. start=1 held with changing a/b during RUN and DONE -> only the first operands are used. A second start asserted in the cycle after done is accepted, giving back-to-back results with one idle cycle between done pulses.
6. rst=1 in the second RUN cycle -> next cycle busy=0, done=0, sum=0, co=0, ovf=0, and no done pulse appears. A new start then completes normally (e.g. 16'h00FF + 16'h0001 = 16'h0100). Repeat with WORDS=1, SIZE=8: 8'hFF + 8'h01 -> sum=8'h00, co=1, done 2 cycles after start.
